// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   state_t      : scanner FSM states (SCAN, CONFIRM, RELEASE)
//   ROW_IDLE     : row pattern with no key pulling any row low
//   COL_RESET    : column drive pattern for column 0 (active-low, one-hot)
//   CODE_*       : bit positions of the row/column fields inside key_code
//   one_low()    : true when exactly one row bit is low
//   low_idx()    : index of the low row bit (only meaningful when one_low())
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        CONFIRM,
        RELEASE
    } state_t;

    localparam logic [3:0] ROW_IDLE  = 4'b1111;
    localparam logic [3:0] COL_RESET = 4'b1110;

    localparam int unsigned CODE_ROW_MSB = 3;
    localparam int unsigned CODE_ROW_LSB = 2;
    localparam int unsigned CODE_COL_MSB = 1;
    localparam int unsigned CODE_COL_LSB = 0;

    function automatic logic one_low(input logic [3:0] r);
        logic [3:0] l;
        l = ~r;
        // A non-zero value with a single set bit clears to zero when ANDed with itself minus one.
        return (l != 4'd0) && ((l & (l - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        if (!r[1]) idx = 2'd1;
        if (!r[2]) idx = 2'd2;
        if (!r[3]) idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle.
//   row       : keypad rows, active-low, pulled high on the board
//   col       : keypad column drive, one-hot active-low
//   key_valid : one-cycle pulse, key_code valid
//   key_code  : {row_idx, col_idx} of the last confirmed key
//   key_led   : bit key_code is set while that key is confirmed held
// master: scanner side; slave: board/consumer side.
interface keypad_scanner_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] key_led;

    modport master (
        input  row,
        output col, key_valid, key_code, key_led
    );

    modport slave (
        output row,
        input  col, key_valid, key_code, key_led
    );
endinterface

// File: rtl/keypad_scanner_scan_timer.sv
// scan_timer: terminal cycle timer used for dwell, debounce and repeat periods.
//   clk  : system clock
//   rst  : asynchronous active-low reset (count returns to 0)
//   load : restart the period (count back to 0); has priority over en
//   en   : count this cycle
//   tick : high on the N-th enabled cycle since the last load; stays high
//          while enabled once the count has saturated at its terminal value
module scan_timer #(
    parameter int unsigned N = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tick
);

    localparam int unsigned W    = $clog2(N + 1);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + W'(1);
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce.
// Drives one column low at a time, samples the rows on the last dwell cycle,
// debounces a single-key press, emits a one-cycle key_valid with key_code,
// and keeps a pressed-key LED map until the key is debounced as released.
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset
//   kp  : keypad_scanner_if.master (row in; col, key_valid, key_code, key_led out)
// Optional feature: define KEYPAD_REPEAT_EN for auto-repeat of a held key
// every REPEAT_CYC cycles; without it REPEAT_CYC is unused and no repeat
// timer exists.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned REPEAT_CYC   = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master kp
);

    state_t     state, state_nx;
    logic [1:0] col_idx;
    logic [1:0] cand_row;
    logic [3:0] cand_pat;
    logic [3:0] code_nx;

    logic row_ok, row_idle, row_single;
    logic dwell_load, dwell_en, dwell_tick;
    logic deb_load, deb_en, deb_tick;
    logic col_step, capture, press, rel, rpt_fire, pulse;

    assign cand_pat   = ~(4'b0001 << cand_row);
    assign row_ok     = (kp.row == cand_pat);
    assign row_idle   = (kp.row == ROW_IDLE);
    assign row_single = one_low(kp.row);

    always_comb begin
        code_nx = '0;
        code_nx[CODE_ROW_MSB:CODE_ROW_LSB] = cand_row;
        code_nx[CODE_COL_MSB:CODE_COL_LSB] = col_idx;
    end

    scan_timer #(.N(SCAN_DIV)) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .load (dwell_load),
        .en   (dwell_en),
        .tick (dwell_tick)
    );

    scan_timer #(.N(DEBOUNCE_CYC)) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .load (deb_load),
        .en   (deb_en),
        .tick (deb_tick)
    );

`ifdef KEYPAD_REPEAT_EN
    logic rpt_load, rpt_en, rpt_tick;

    // Runs only while the confirmed key is held in RELEASE; any other row
    // pattern (release or glitch) restarts the period, as does each pulse.
    assign rpt_en   = (state == RELEASE) && row_ok;
    assign rpt_load = !rpt_en || rpt_tick;
    assign rpt_fire = rpt_en && rpt_tick;

    scan_timer #(.N(REPEAT_CYC)) u_repeat (
        .clk  (clk),
        .rst  (rst),
        .load (rpt_load),
        .en   (rpt_en),
        .tick (rpt_tick)
    );
`else
    logic unused_repeat_cyc;
    assign unused_repeat_cyc = ^REPEAT_CYC;
    assign rpt_fire = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SCAN;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            SCAN:    if (dwell_tick && row_single) state_nx = CONFIRM;
            CONFIRM: begin
                if (!row_ok)       state_nx = SCAN;
                else if (deb_tick) state_nx = RELEASE;
            end
            RELEASE: if (deb_tick) state_nx = SCAN;
            default: state_nx = SCAN;
        endcase
    end

    // Control strobes; timers are held at zero outside the state that uses
    // them so every entry starts a full period.
    always_comb begin
        dwell_en   = (state == SCAN);
        dwell_load = (state != SCAN) || dwell_tick;
        deb_en     = ((state == CONFIRM) && row_ok) || ((state == RELEASE) && row_idle);
        deb_load   = (state == SCAN)
                  || ((state == CONFIRM) && deb_tick)
                  || ((state == RELEASE) && !row_idle);
        capture    = (state == SCAN) && dwell_tick && row_single;
        press      = (state == CONFIRM) && row_ok && deb_tick;
        rel        = (state == RELEASE) && deb_tick;
        col_step   = ((state == SCAN) && dwell_tick && !row_single)
                  || ((state == CONFIRM) && !row_ok)
                  || rel;
        pulse      = press || rpt_fire;
    end

    // Column index, candidate row and key outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_idx      <= '0;
            cand_row     <= '0;
            kp.key_valid <= 1'b0;
            kp.key_code  <= '0;
            kp.key_led   <= '0;
        end else begin
            kp.key_valid <= pulse;
            if (capture)  cand_row <= low_idx(kp.row);
            if (col_step) col_idx  <= col_idx + 2'd1;
            if (pulse) begin
                kp.key_code <= code_nx;
                kp.key_led  <= 16'd1 << code_nx;
            end else if (rel) begin
                kp.key_led  <= '0;
            end
        end
    end

    assign kp.col = ~(~COL_RESET << col_idx);

endmodule
